// File: rtl/sobel_linebuf_ctrl.sv
// Line-buffer sequencer for a 3x3 Sobel window: writes the current line into one of three
// external RAMs and presents (row-2, row-1, row) pixels of the same column one cycle later.
module sobel_linebuf_ctrl #(
   parameter int IMG_WIDTH  = 640,
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 8,
   parameter int ROW_WIDTH  = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_sof,
   output logic [2:0]            ram_we,
   output logic [ADDR_WIDTH-1:0] ram_wr_addr,
   output logic [DATA_WIDTH-1:0] ram_wr_data,
   output logic [ADDR_WIDTH-1:0] ram_rd_addr,
   input  logic [DATA_WIDTH-1:0] ram_rd_data0,
   input  logic [DATA_WIDTH-1:0] ram_rd_data1,
   input  logic [DATA_WIDTH-1:0] ram_rd_data2,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_top,
   output logic [DATA_WIDTH-1:0] out_mid,
   output logic [DATA_WIDTH-1:0] out_bot,
   output logic [ADDR_WIDTH-1:0] out_col,
   output logic [ROW_WIDTH-1:0]  out_row,
   output logic                  out_sol,
   output logic                  out_eol,
   output logic                  out_win
);

   localparam logic [ADDR_WIDTH-1:0] LAST_COL = ADDR_WIDTH'(IMG_WIDTH - 1);

   typedef enum logic {WAIT_SOF, ACTIVE} state_t;

   function automatic logic [ROW_WIDTH-1:0] sat_inc_row(input logic [ROW_WIDTH-1:0] r);
      return (r == '1) ? r : r + ROW_WIDTH'(1);
   endfunction

   function automatic logic [1:0] rot3(input logic [1:0] w);
      return (w == 2'd2) ? 2'd0 : w + 2'd1;
   endfunction

   function automatic logic [2:0] onehot3(input logic [1:0] w);
      return (w == 2'd0) ? 3'b001 : (w == 2'd1) ? 3'b010 : 3'b100;
   endfunction

   state_t                 state, state_nxt;
   logic [ADDR_WIDTH-1:0]  col, col_nxt, col_use;
   logic [ROW_WIDTH-1:0]   row, row_nxt, row_use;
   logic [1:0]             wsel, wsel_nxt, wsel_use;
   logic                   accept, issue;

   logic                   vld_p1;
   logic [DATA_WIDTH-1:0]  bot_p1;
   logic [ADDR_WIDTH-1:0]  col_p1;
   logic [ROW_WIDTH-1:0]   row_p1;
   logic [1:0]             wsel_p1;
   logic [DATA_WIDTH-1:0]  top_sel, mid_sel;

   assign in_ready = !vld_p1 || out_ready;
   assign accept   = in_valid && in_ready;
   assign issue    = accept && (in_sof || (state == ACTIVE));

   // A start-of-frame pixel always lands at (0,0) in RAM 0, whatever the current position.
   assign col_use  = in_sof ? '0 : col;
   assign row_use  = in_sof ? '0 : row;
   assign wsel_use = in_sof ? 2'd0 : wsel;

   always_comb begin
      state_nxt   = state;
      col_nxt     = col;
      row_nxt     = row;
      wsel_nxt    = wsel;
      ram_we      = 3'b000;
      ram_wr_addr = '0;
      ram_wr_data = '0;
      ram_rd_addr = col_p1;
      if (issue) begin
         state_nxt   = ACTIVE;
         ram_we      = onehot3(wsel_use);
         ram_wr_addr = col_use;
         ram_wr_data = in_data;
         ram_rd_addr = col_use;
         if (col_use == LAST_COL) begin
            col_nxt  = '0;
            row_nxt  = sat_inc_row(row_use);
            wsel_nxt = rot3(wsel_use);
         end else begin
            col_nxt  = col_use + ADDR_WIDTH'(1);
            row_nxt  = row_use;
            wsel_nxt = wsel_use;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= WAIT_SOF;
         col     <= '0;
         row     <= '0;
         wsel    <= 2'd0;
         vld_p1  <= 1'b0;
         bot_p1  <= '0;
         col_p1  <= '0;
         row_p1  <= '0;
         wsel_p1 <= 2'd0;
      end else begin
         state <= state_nxt;
         col   <= col_nxt;
         row   <= row_nxt;
         wsel  <= wsel_nxt;
         // ---- stage p1: column registered alongside the RAM read ----
         if (issue) begin
            vld_p1  <= 1'b1;
            bot_p1  <= in_data;
            col_p1  <= col_use;
            row_p1  <= row_use;
            wsel_p1 <= wsel_use;
         end else if (out_ready) begin
            vld_p1  <= 1'b0;
         end
      end
   end

   // The two older lines sit in the RAMs after the one being written, in rotation order.
   always_comb begin
      top_sel = '0;
      mid_sel = '0;
      case (wsel_p1)
         2'd0:    begin top_sel = ram_rd_data1; mid_sel = ram_rd_data2; end
         2'd1:    begin top_sel = ram_rd_data2; mid_sel = ram_rd_data0; end
         2'd2:    begin top_sel = ram_rd_data0; mid_sel = ram_rd_data1; end
         default: begin top_sel = '0;           mid_sel = '0;           end
      endcase
   end

   assign out_valid = vld_p1;
   assign out_top   = (vld_p1 && (row_p1 >= ROW_WIDTH'(2))) ? top_sel : '0;
   assign out_mid   = (vld_p1 && (row_p1 != '0)) ? mid_sel : '0;
   assign out_bot   = vld_p1 ? bot_p1 : '0;
   assign out_col   = col_p1;
   assign out_row   = row_p1;
   assign out_sol   = (col_p1 == '0);
   assign out_eol   = (col_p1 == LAST_COL);
   assign out_win   = (row_p1 >= ROW_WIDTH'(2));

endmodule

// File: tb/tb_sobel_linebuf_ctrl.sv
// Bench for sobel_linebuf_ctrl: three behavioural RAMs, a frame-array reference model with an
// expected-column queue, a table of known raster values, and hand sequences for stall/reset cases.
module tb_sobel_linebuf_ctrl;
   localparam int W  = 4;
   localparam int AW = 10;
   localparam int DW = 8;
   localparam int RW = 10;

   logic          clk = 1'b0;
   logic          rst, in_valid, in_ready, in_sof, out_valid, out_ready;
   logic [DW-1:0] in_data, ram_wr_data, rd0, rd1, rd2, out_top, out_mid, out_bot;
   logic [2:0]    ram_we;
   logic [AW-1:0] ram_wr_addr, ram_rd_addr, out_col;
   logic [RW-1:0] out_row;
   logic          out_sol, out_eol, out_win;

   always #5 clk = ~clk;

   sobel_linebuf_ctrl #(.IMG_WIDTH(W), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROW_WIDTH(RW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_sof(in_sof), .ram_we(ram_we), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
      .ram_rd_addr(ram_rd_addr), .ram_rd_data0(rd0), .ram_rd_data1(rd1), .ram_rd_data2(rd2),
      .out_valid(out_valid), .out_ready(out_ready), .out_top(out_top), .out_mid(out_mid),
      .out_bot(out_bot), .out_col(out_col), .out_row(out_row), .out_sol(out_sol),
      .out_eol(out_eol), .out_win(out_win));

   // Three dual-port RAMs with a registered read port
   logic [DW-1:0] mem0 [0:(1<<AW)-1];
   logic [DW-1:0] mem1 [0:(1<<AW)-1];
   logic [DW-1:0] mem2 [0:(1<<AW)-1];
   initial begin
      for (int i = 0; i < (1<<AW); i++) begin mem0[i] = 8'hEE; mem1[i] = 8'hEE; mem2[i] = 8'hEE; end
   end
   always @(posedge clk) begin
      if (ram_we[0]) mem0[ram_wr_addr] <= ram_wr_data;
      if (ram_we[1]) mem1[ram_wr_addr] <= ram_wr_data;
      if (ram_we[2]) mem2[ram_wr_addr] <= ram_wr_data;
      rd0 <= mem0[ram_rd_addr];
      rd1 <= mem1[ram_rd_addr];
      rd2 <= mem2[ram_rd_addr];
   end

   // Reference model: whole frame kept as a pixel array, expected columns queued in order
   typedef struct {
      logic [DW-1:0] top, mid, bot;
      int            col, row;
   } col_t;
   col_t          q[$];
   logic [DW-1:0] pix [0:63][0:W-1];
   int            m_r, m_c;
   bit            m_active;
   int            n_vec = 0, n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input bit v, input logic [DW-1:0] d, input bit s, input bit ordy,
                        input bit r, output logic [2:0] we_seen, output bit acc);
      col_t       e;
      bit         exp_rdy, iss;
      logic [2:0] exp_we;
      @(negedge clk);
      rst = r; in_valid = v; in_data = d; in_sof = s; out_ready = ordy;
      #1;
      we_seen = ram_we;
      acc     = 1'b0;
      if (r) begin
         q.delete(); m_active = 0; m_r = 0; m_c = 0;
      end else begin
         chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
         exp_rdy = (q.size() == 0) || ordy;
         chk("in_ready", 32'(in_ready), 32'(exp_rdy));
         if (q.size() != 0) begin
            e = q[0];
            chk("top", 32'(out_top), 32'(e.top));
            chk("mid", 32'(out_mid), 32'(e.mid));
            chk("bot", 32'(out_bot), 32'(e.bot));
            chk("col", 32'(out_col), 32'(e.col));
            chk("row", 32'(out_row), 32'(e.row));
            chk("sol", 32'(out_sol), 32'(e.col == 0));
            chk("eol", 32'(out_eol), 32'(e.col == W-1));
            chk("win", 32'(out_win), 32'(e.row >= 2));
            if (ordy) void'(q.pop_front());
         end
         acc = v && exp_rdy;
         iss = acc && (s || m_active);
         if (iss && s) begin m_active = 1; m_r = 0; m_c = 0; end
         exp_we = iss ? 3'(1 << (m_r % 3)) : 3'b000;
         chk("ram_we", 32'(ram_we), 32'(exp_we));
         if (iss) begin
            chk("rd_addr", 32'(ram_rd_addr), 32'(m_c));
            chk("wr_addr", 32'(ram_wr_addr), 32'(m_c));
            chk("wr_data", 32'(ram_wr_data), 32'(d));
            pix[m_r][m_c] = d;
            e.top = '0; e.mid = '0;
            if (m_r >= 2) e.top = pix[m_r-2][m_c];
            if (m_r >= 1) e.mid = pix[m_r-1][m_c];
            e.bot = d; e.col = m_c; e.row = m_r;
            q.push_back(e);
            m_c++;
            if (m_c == W) begin m_c = 0; if (m_r < 63) m_r++; end
         end
      end
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [DW-1:0] data;
      bit            sof;
      logic [2:0]    we;
      logic [DW-1:0] top, mid, bot;
      int            col, row;
      bit            win;
   } vec_t;
   vec_t tbl [0:19];

   logic [2:0]    we;
   bit            acc;
   logic [DW-1:0] s_top, s_mid, s_bot, d;
   logic [AW-1:0] s_col;
   int            sent, cyc;

   initial begin
      for (int i = 0; i < 20; i++) begin
         int r, c;
         r = i / W; c = i % W;
         tbl[i].data = 8'(10*r + c);
         tbl[i].sof  = (i == 0);
         tbl[i].we   = 3'(1 << (r % 3));
         tbl[i].top  = (r >= 2) ? 8'(10*(r-2) + c) : 8'd0;
         tbl[i].mid  = (r >= 1) ? 8'(10*(r-1) + c) : 8'd0;
         tbl[i].bot  = 8'(10*r + c);
         tbl[i].col  = c;
         tbl[i].row  = r;
         tbl[i].win  = (r >= 2);
      end
      rst = 1; in_valid = 0; in_data = 0; in_sof = 0; out_ready = 1;

      // reset state
      drive(0, 0, 0, 1, 1, we, acc);
      drive(0, 0, 0, 1, 1, we, acc);
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_we", 32'(ram_we), 0);
      chk("rst_top", 32'(out_top), 0);
      chk("rst_mid", 32'(out_mid), 0);
      chk("rst_bot", 32'(out_bot), 0);
      chk("rst_rdaddr", 32'(ram_rd_addr), 0);
      chk("rst_col", 32'(out_col), 0);
      chk("rst_row", 32'(out_row), 0);

      // five lines of 10*row+col, continuous flow
      for (int i = 0; i < 20; i++) begin
         drive(1, tbl[i].data, tbl[i].sof, 1, 0, we, acc);
         chk("tbl_we", 32'(we), 32'(tbl[i].we));
         chk("tbl_valid", 32'(out_valid), 1);
         chk("tbl_top", 32'(out_top), 32'(tbl[i].top));
         chk("tbl_mid", 32'(out_mid), 32'(tbl[i].mid));
         chk("tbl_bot", 32'(out_bot), 32'(tbl[i].bot));
         chk("tbl_col", 32'(out_col), 32'(tbl[i].col));
         chk("tbl_row", 32'(out_row), 32'(tbl[i].row));
         chk("tbl_win", 32'(out_win), 32'(tbl[i].win));
      end
      drive(0, 0, 0, 1, 0, we, acc);
      chk("drain_valid", 32'(out_valid), 0);

      // stall for 5 cycles mid-line
      for (int i = 0; i < 6; i++) drive(1, 8'($urandom), (i == 0), 1, 0, we, acc);
      d = 8'($urandom);
      drive(1, d, 0, 0, 0, we, acc);
      s_top = out_top; s_mid = out_mid; s_bot = out_bot; s_col = out_col;
      for (int i = 0; i < 4; i++) begin
         drive(1, d, 0, 0, 0, we, acc);
         chk("stall_rdy", 32'(in_ready), 0);
         chk("stall_we", 32'(we), 0);
         chk("stall_top", 32'(out_top), 32'(s_top));
         chk("stall_mid", 32'(out_mid), 32'(s_mid));
         chk("stall_bot", 32'(out_bot), 32'(s_bot));
         chk("stall_col", 32'(out_col), 32'(s_col));
      end
      for (int i = 0; i < 8; i++) begin
         drive(1, d, 0, 1, 0, we, acc);
         d = 8'($urandom);
      end
      drive(0, 0, 0, 1, 0, we, acc);
      chk("stall_drained", q.size(), 0);

      // random out_ready with in_valid held high
      sent = 0; cyc = 0; d = 8'($urandom);
      while (sent < 6*W && cyc < 600) begin
         drive(1, d, (sent == 0), 1'($urandom), 0, we, acc);
         if (acc) begin sent++; d = 8'($urandom); end
         cyc++;
      end
      chk("rand_sent", sent, 6*W);
      for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 0, we, acc);
      chk("rand_drained", q.size(), 0);

      // pixels before the first in_sof are dropped
      drive(0, 0, 0, 1, 1, we, acc);
      for (int i = 0; i < 3; i++) begin
         drive(1, 8'(50 + i), 0, 1, 0, we, acc);
         chk("nosof_we", 32'(we), 0);
         chk("nosof_valid", 32'(out_valid), 0);
      end
      drive(1, 8'd77, 1, 0, 0, we, acc);
      chk("sof_valid", 32'(out_valid), 1);
      chk("sof_row", 32'(out_row), 0);
      chk("sof_col", 32'(out_col), 0);
      chk("sof_bot", 32'(out_bot), 77);
      drive(0, 0, 0, 1, 0, we, acc);

      // reset in the middle of line 2, then a clean frame
      for (int i = 0; i < 2*W + 2; i++) drive(1, 8'($urandom), (i == 0), 1, 0, we, acc);
      drive(1, 8'($urandom), 0, 1, 1, we, acc);
      chk("rst_mid_valid", 32'(out_valid), 0);
      for (int i = 0; i < 2*W; i++) begin
         drive(1, 8'($urandom | 1), (i == 0), 1, 0, we, acc);
         if (i < W) begin
            chk("new_top", 32'(out_top), 0);
            chk("new_mid", 32'(out_mid), 0);
         end
      end
      drive(0, 0, 0, 1, 0, we, acc);
      chk("end_drained", q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
